// File: rtl/fp_mac_issue_arbiter.sv
// Purpose : shares one FP MAC unit between the core FP issue path (r0) and the
//           div/sqrt sequencer (r1); round-robin issue, per-op tag, writeback routing.
// Latency : issue and writeback are both combinational (0 cycles); tag/counter state
//           updates on the next edge, so a freed tag is reusable one cycle after its ack.
// Backpr. : no grant without u_ready and a free tag; r1 is capped at R1_MAX_OUTSTANDING
//           ops in flight; u_ack follows the owning requester's ack.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   r0_*/r1_* request     valid/ready/id/inputs issue handshake per requester
//   u_new_request/u_ready/u_id/u_inputs   issue side of the MAC unit
//   u_done/u_wb_id/u_rd/u_ack             writeback side of the MAC unit
//   r0_*/r1_* writeback   done/rd/wb_id/ack result handshake per requester
//
// Build option: FP_MAC_ARB_FIXED_PRIO_EN -- requester 0 always wins when eligible and
// the round-robin pointer is dropped; the requester 1 outstanding cap still applies.

module fp_mac_issue_arbiter #(
    parameter int NUM_TAGS           = 8,
    parameter int ID_W               = 3,
    parameter int R1_MAX_OUTSTANDING = 4,
    parameter int INPUTS_W           = 104   // fp_mac_inputs_t: 3 x 34-bit operands + op
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r0_valid,
    output logic                r0_ready,
    input  logic [ID_W-1:0]     r0_id,
    input  logic [INPUTS_W-1:0] r0_inputs,
    input  logic                r1_valid,
    output logic                r1_ready,
    input  logic [ID_W-1:0]     r1_id,
    input  logic [INPUTS_W-1:0] r1_inputs,
    output logic                u_new_request,
    input  logic                u_ready,
    output logic [ID_W-1:0]     u_id,
    output logic [INPUTS_W-1:0] u_inputs,
    input  logic                u_done,
    input  logic [ID_W-1:0]     u_wb_id,
    input  logic [33:0]         u_rd,
    output logic                u_ack,
    output logic                r0_done,
    output logic [33:0]         r0_rd,
    output logic [ID_W-1:0]     r0_wb_id,
    input  logic                r0_ack,
    output logic                r1_done,
    output logic [33:0]         r1_rd,
    output logic [ID_W-1:0]     r1_wb_id,
    input  logic                r1_ack
);

    localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int CNT_W = $clog2(R1_MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] R1_MAX = CNT_W'(R1_MAX_OUTSTANDING);

    logic [NUM_TAGS-1:0] free_mask_q, free_mask_d;
    logic                owner_q   [NUM_TAGS];
    logic [ID_W-1:0]     orig_id_q [NUM_TAGS];
    logic [CNT_W-1:0]    r1_cnt_q, r1_cnt_d;

    logic             can_grant, r1_elig, grant0, grant1, grant_any;
    logic [TAG_W-1:0] alloc_tag, wb_idx;
    logic             wb_owner, r1_ack_fire;

    // Lowest free tag: scanning downward leaves the lowest set bit as the last write.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_mask_q[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign can_grant = !rst && u_ready && (|free_mask_q);
    assign r1_elig   = r1_valid && (r1_cnt_q < R1_MAX);

`ifdef FP_MAC_ARB_FIXED_PRIO_EN
    assign grant0 = can_grant && r0_valid;
    assign grant1 = can_grant && r1_elig && !r0_valid;
`else
    logic rr_last_q;

    // On contention the requester that did not win last time goes first.
    assign grant0 = can_grant && r0_valid && (!r1_elig || rr_last_q);
    assign grant1 = can_grant && r1_elig && (!r0_valid || !rr_last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else if (grant0 || grant1) begin
            rr_last_q <= grant1;
        end
    end
`endif

    assign grant_any     = grant0 || grant1;
    assign r0_ready      = grant0;
    assign r1_ready      = grant1;
    assign u_new_request = grant_any;
    assign u_id          = grant_any ? ID_W'(alloc_tag) : '0;
    assign u_inputs      = grant1 ? r1_inputs : r0_inputs;

    // Writeback routing straight from the tag table.
    assign wb_idx      = u_wb_id[TAG_W-1:0];
    assign wb_owner    = owner_q[wb_idx];
    assign r0_done     = !rst && u_done && !wb_owner;
    assign r1_done     = !rst && u_done && wb_owner;
    assign r0_rd       = u_rd;
    assign r1_rd       = u_rd;
    assign r0_wb_id    = orig_id_q[wb_idx];
    assign r1_wb_id    = orig_id_q[wb_idx];
    assign u_ack       = (r0_done && r0_ack) || (r1_done && r1_ack);
    assign r1_ack_fire = u_ack && wb_owner;

    // The acked tag is in use and the allocated tag is free, so the two never collide;
    // allocation sees the pre-update mask, so a tag freed this cycle is not reissued yet.
    always_comb begin
        free_mask_d = free_mask_q;
        if (grant_any) begin
            free_mask_d[alloc_tag] = 1'b0;
        end
        if (u_ack) begin
            free_mask_d[wb_idx] = 1'b1;
        end
    end

    always_comb begin
        r1_cnt_d = r1_cnt_q;
        case ({grant1, r1_ack_fire})
            2'b10:   r1_cnt_d = r1_cnt_q + CNT_W'(1);
            2'b01:   r1_cnt_d = r1_cnt_q - CNT_W'(1);
            default: r1_cnt_d = r1_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_mask_q <= '1;
            r1_cnt_q    <= '0;
        end else begin
            free_mask_q <= free_mask_d;
            r1_cnt_q    <= r1_cnt_d;
        end
    end

    // Table contents are meaningless while the tag is free, so no reset is needed.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            owner_q[alloc_tag]   <= grant1;
            orig_id_q[alloc_tag] <= grant1 ? r1_id : r0_id;
        end
    end

    // A result for a tag that was never issued (or already retired) is a MAC-side bug.
    a_wb_tag_live : assert property (@(posedge clk) disable iff (rst)
        u_done |-> !free_mask_q[wb_idx]);

endmodule

// File: tb/tb_fp_mac_issue_arbiter.sv
module tb_fp_mac_issue_arbiter;

    localparam int NT = 8, IW = 3, R1MAX = 4, INW = 104;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           r0_valid, r0_ready, r1_valid, r1_ready;
    logic [IW-1:0]  r0_id, r1_id, u_id, u_wb_id, r0_wb_id, r1_wb_id;
    logic [INW-1:0] r0_inputs, r1_inputs, u_inputs;
    logic           u_new_request, u_ready, u_done, u_ack;
    logic [33:0]    u_rd, r0_rd, r1_rd;
    logic           r0_done, r1_done, r0_ack, r1_ack;

    fp_mac_issue_arbiter #(.NUM_TAGS(NT), .ID_W(IW), .R1_MAX_OUTSTANDING(R1MAX), .INPUTS_W(INW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_id(r0_id), .r0_inputs(r0_inputs),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_id(r1_id), .r1_inputs(r1_inputs),
        .u_new_request(u_new_request), .u_ready(u_ready), .u_id(u_id), .u_inputs(u_inputs),
        .u_done(u_done), .u_wb_id(u_wb_id), .u_rd(u_rd), .u_ack(u_ack),
        .r0_done(r0_done), .r0_rd(r0_rd), .r0_wb_id(r0_wb_id), .r0_ack(r0_ack),
        .r1_done(r1_done), .r1_rd(r1_rd), .r1_wb_id(r1_wb_id), .r1_ack(r1_ack)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the set of in-flight ops, who owns each and its original id.
    bit            m_busy [NT];
    bit            m_own  [NT];
    logic [IW-1:0] m_oid  [NT];
    int            m_rr = 1;

    // Observed DUT values from the most recent step, for directed scenario checks.
    logic          obs_r0rdy, obs_r1rdy, obs_unew, obs_uack, obs_r0done, obs_r1done;
    logic [IW-1:0] obs_uid, obs_r0wb, obs_r1wb;

    task automatic idle();
        r0_valid = 0; r1_valid = 0; r0_id = 0; r1_id = 0;
        r0_inputs = INW'({$urandom(), $urandom(), $urandom(), $urandom()});
        r1_inputs = INW'({$urandom(), $urandom(), $urandom(), $urandom()});
        u_ready = 0; u_done = 0; u_wb_id = 0; u_rd = 34'({$urandom(), $urandom()});
        r0_ack = 0; r1_ack = 0;
    endtask

    // One clock: predict outputs from the model, compare mid-cycle, then advance the model.
    task automatic step();
        int ftag, r1n, win;
        bit e0, e1, d0, d1, ack;
        @(negedge clk);
        ftag = -1;
        for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) ftag = t;
        r1n = 0;
        for (int t = 0; t < NT; t++) if (m_busy[t] && m_own[t]) r1n++;
        e0 = r0_valid;
        e1 = r1_valid && (r1n < R1MAX);
        win = -1;
        if (!rst && u_ready && ftag >= 0) begin
            if (e0 && e1) begin
`ifdef FP_MAC_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = (m_rr == 1) ? 0 : 1;
`endif
            end else if (e0) win = 0;
            else if (e1) win = 1;
        end
        d0 = 0; d1 = 0; ack = 0;
        if (!rst && u_done) begin
            if (m_own[u_wb_id]) d1 = 1; else d0 = 1;
            ack = d1 ? r1_ack : r0_ack;
        end
        chk("r0_ready", r0_ready, win == 0);
        chk("r1_ready", r1_ready, win == 1);
        chk("u_new_request", u_new_request, win >= 0);
        chk("u_id", u_id, (win >= 0) ? ftag : 0);
        chk("u_inputs", u_inputs, (win == 1) ? r1_inputs : r0_inputs);
        chk("r0_done", r0_done, d0);
        chk("r1_done", r1_done, d1);
        chk("u_ack", u_ack, ack);
        if (d0) begin
            chk("r0_wb_id", r0_wb_id, m_oid[u_wb_id]);
            chk("r0_rd", r0_rd, u_rd);
        end
        if (d1) begin
            chk("r1_wb_id", r1_wb_id, m_oid[u_wb_id]);
            chk("r1_rd", r1_rd, u_rd);
        end
        obs_r0rdy = r0_ready; obs_r1rdy = r1_ready; obs_unew = u_new_request; obs_uack = u_ack;
        obs_r0done = r0_done; obs_r1done = r1_done; obs_uid = u_id;
        obs_r0wb = r0_wb_id; obs_r1wb = r1_wb_id;
        @(posedge clk);
        if (rst) begin
            for (int t = 0; t < NT; t++) m_busy[t] = 0;
            m_rr = 1;
        end else begin
            if (ack) m_busy[u_wb_id] = 0;
            if (win >= 0) begin
                m_busy[ftag] = 1;
                m_own[ftag]  = (win == 1);
                m_oid[ftag]  = (win == 1) ? r1_id : r0_id;
                m_rr         = win;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        bit seq[4];
        int grants;
        int busy_q[$];
`ifdef FP_MAC_ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0};
`else
        seq = '{0, 1, 0, 1};
`endif
        for (int t = 0; t < NT; t++) begin m_busy[t] = 0; m_own[t] = 0; m_oid[t] = 0; end

        // Outputs stay low during reset even with every input asserted.
        idle();
        rst = 1; r0_valid = 1; r1_valid = 1; u_ready = 1; r0_ack = 1; r1_ack = 1;
        step(); step();
        chk("rst_new_request", obs_unew, 0);
        chk("rst_ready", {obs_r0rdy, obs_r1rdy}, 0);
        idle(); rst = 0;

        // First grant after reset goes to tag 0, and the id comes back on writeback.
        r0_valid = 1; r0_id = 5; u_ready = 1;
        step();
        chk("tp1_new", obs_unew, 1);
        chk("tp1_tag", obs_uid, 0);
        chk("tp1_r0_ready", obs_r0rdy, 1);
        idle(); u_done = 1; u_wb_id = 0; r0_ack = 1;
        step();
        chk("tp1_r0_done", obs_r0done, 1);
        chk("tp1_wb_id", obs_r0wb, 5);
        chk("tp1_u_ack", obs_uack, 1);

        // Contention: alternating winners on consecutive tags.
        do_reset();
        r0_valid = 1; r1_valid = 1; u_ready = 1; r0_id = 2; r1_id = 6;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_winner", obs_r1rdy, seq[i]);
            chk("rr_tag", obs_uid, i);
        end

        // Requester 1 cap, then one ack re-enables exactly one grant a cycle later.
        do_reset();
        r1_valid = 1; u_ready = 1;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            r1_id = IW'(i);
            step();
            grants += int'(obs_r1rdy);
        end
        chk("r1_cap_grants", grants, 4);
        chk("r1_cap_ready", obs_r1rdy, 0);
        u_done = 1; u_wb_id = 0; r1_ack = 1;
        step();
        chk("r1_ack_same_cycle", obs_r1rdy, 0);
        chk("r1_ack_u_ack", obs_uack, 1);
        u_done = 0; r1_ack = 0;
        step();
        chk("r1_regrant", obs_r1rdy, 1);
        chk("r1_regrant_tag", obs_uid, 0);

        // Full pool: no grant until an ack, and the freed tag only a cycle later.
        do_reset();
        r0_valid = 1; u_ready = 1;
        for (int i = 0; i < NT; i++) step();
        step();
        chk("full_ready", obs_r0rdy, 0);
        u_done = 1; u_wb_id = 3; r0_ack = 1;
        step();
        chk("full_ack_ready", obs_r0rdy, 0);
        u_done = 0; r0_ack = 0;
        step();
        chk("full_regrant", obs_r0rdy, 1);
        chk("full_regrant_tag", obs_uid, 3);

        // Out-of-order writeback with a stalled requester 1.
        do_reset();
        u_ready = 1; r0_valid = 1; r0_id = 1;
        step();
        r0_id = 4;
        step();
        r0_valid = 0; r1_valid = 1; r1_id = 7;
        step();
        r1_valid = 0; u_done = 1; u_wb_id = 2; r1_ack = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ooo_r1_done", obs_r1done, 1);
            chk("ooo_r0_done", obs_r0done, 0);
            chk("ooo_r1_wb_id", obs_r1wb, 7);
            chk("ooo_stall_ack", obs_uack, 0);
        end
        r1_ack = 1;
        step();
        chk("ooo_r1_ack", obs_uack, 1);
        r1_ack = 0; u_wb_id = 0; r0_ack = 1;
        step();
        chk("ooo_r0_done", obs_r0done, 1);
        chk("ooo_r0_wb_id", obs_r0wb, 1);

        // Reset with ops in flight: counter and pool both return to empty.
        u_done = 0; r0_ack = 0; r1_valid = 1;
        step(); step();
        do_reset();
        r1_valid = 1; u_ready = 1;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            grants += int'(obs_r1rdy);
            chk("post_rst_tag", obs_uid, i);
        end
        chk("post_rst_r1_grants", grants, 4);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst       = ($urandom_range(0, 199) == 0);
            r0_valid  = ($urandom_range(0, 99) < 55);
            r1_valid  = ($urandom_range(0, 99) < 55);
            r0_id     = IW'($urandom());
            r1_id     = IW'($urandom());
            u_ready   = ($urandom_range(0, 99) < 80);
            r0_ack    = ($urandom_range(0, 99) < 70);
            r1_ack    = ($urandom_range(0, 99) < 70);
            busy_q.delete();
            for (int t = 0; t < NT; t++) if (m_busy[t]) busy_q.push_back(t);
            if (busy_q.size() > 0 && $urandom_range(0, 99) < 50) begin
                u_done  = 1;
                u_wb_id = IW'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
